// File: rtl/sfifo_pop_pkg.sv
// Shared types and constants for the sfifo pop-side stream controller.
package sfifo_pop_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN} pop_st_t;

  localparam int STAT_W = 32;

  // One slot per possible in-flight read plus one being consumed and one landing.
  function automatic int obuf_depth(input int dly);
    return dly + 2;
  endfunction
endpackage

// File: rtl/sfifo_pop_obuf.sv
// Circular output buffer: push at tail, head drives the stream, registered count/valid.
module sfifo_pop_obuf
  import sfifo_pop_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [$clog2(D+1)-1:0] cnt,
  output logic [W-1:0]           head,
  output logic                   vld
);
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D+1);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;

  // Pointers wrap at D, which need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(D-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt_nxt;
      vld <= (cnt_nxt != '0);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/sfifo_pop_stream.sv
// Pop-side controller for sfifo: credit-based fifo_re, latency tracking, valid/ready output.
// Optional SFIFO_POP_STATS_EN adds saturating pop_cnt / stall_cnt outputs.
module sfifo_pop_stream
  import sfifo_pop_pkg::*;
#(
  parameter int FIFO_D   = 12,
  parameter int FIFO_W   = 32,
  parameter int FIFO_DLY = 0,
  parameter int FIFO_ADR = $clog2(FIFO_D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush_req,
  output logic              fifo_re,
  output logic              fifo_fsh,
  input  logic [FIFO_W-1:0] fifo_rd,
  input  logic              fifo_empt,
  input  logic              fifo_udf,
  input  logic [FIFO_ADR:0] fifo_len,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic [FIFO_W-1:0] m_dat,
  output logic              busy,
  output logic              udf_err
`ifdef SFIFO_POP_STATS_EN
  ,
  output logic [STAT_W-1:0] pop_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);
  localparam int OBUF_D = obuf_depth(FIFO_DLY);
  localparam int CW     = $clog2(OBUF_D+1);

  pop_st_t       state;
  logic [1:0]    drn_cnt;
  logic [CW-1:0] obuf_cnt;
  logic [CW-1:0] infl_cnt;
  logic          pop, push, land, flushing;
  logic          unused_len;

  assign pop        = m_vld && m_rdy;
  assign flushing   = (state == ST_FLUSH);
  assign push       = land && (state != ST_DRAIN);
  assign unused_len = ^fifo_len;

  // Tracker: the oldest bit marks the cycle fifo_rd is valid for a past fifo_re.
  generate
    if (FIFO_DLY == 0) begin : g_nodly
      assign land     = fifo_re;
      assign infl_cnt = '0;
    end else begin : g_dly
      logic [FIFO_DLY-1:0] vld_pipe;

      always_ff @(posedge clk) begin
        if (rst || flushing) vld_pipe <= '0;
        else                 vld_pipe <= FIFO_DLY'({vld_pipe, fifo_re});
      end

      always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < FIFO_DLY; i++) infl_cnt = infl_cnt + CW'(vld_pipe[i]);
      end

      assign land = vld_pipe[FIFO_DLY-1];
    end
  endgenerate

  // Credit: buffered + in flight, less this cycle's pop, must leave room for one more.
  always_comb begin
    fifo_re = 1'b0;
    if (!rst && state == ST_RUN && !flush_req && en && !fifo_empt)
      fifo_re = ({1'b0, obuf_cnt} + {1'b0, infl_cnt}) <
                ((CW+1)'(OBUF_D) + (CW+1)'(pop));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      fifo_fsh <= 1'b0;
      drn_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: if (flush_req) begin
          state    <= ST_FLUSH;
          fifo_fsh <= 1'b1;
        end
        ST_FLUSH: begin
          fifo_fsh <= 1'b0;
          drn_cnt  <= 2'(FIFO_DLY-1);
          state    <= (FIFO_DLY > 0) ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: begin
          if (drn_cnt == '0) state <= ST_RUN;
          else               drn_cnt <= drn_cnt - 2'd1;
        end
        default: begin
          state    <= ST_RUN;
          fifo_fsh <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           udf_err <= 1'b0;
    else if (fifo_udf) udf_err <= 1'b1;
  end

  sfifo_pop_obuf #(.W(FIFO_W), .D(OBUF_D)) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .clr      (flushing),
    .push     (push),
    .push_dat (fifo_rd),
    .pop      (pop),
    .cnt      (obuf_cnt),
    .head     (m_dat),
    .vld      (m_vld)
  );

  assign busy = (obuf_cnt != '0) || (infl_cnt != '0);

`ifdef SFIFO_POP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && pop_cnt != '1)                  pop_cnt   <= pop_cnt + STAT_W'(1);
      if (m_vld && !m_rdy && stall_cnt != '1)    stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_sfifo_pop_stream.sv
// Directed bench: three DUTs (FIFO_DLY = 0, 1, 2), each fed by a small FIFO model.
module tb_sfifo_pop_stream;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] en = '0, flush_req = '0, m_rdy = '0, fifo_udf = '0;
  logic [NI-1:0] fifo_re, fifo_fsh, fifo_empt, m_vld, busy, udf_err;
  logic [NI-1:0][31:0] fifo_rd, m_dat;
  logic [NI-1:0][4:0]  fifo_len;
`ifdef SFIFO_POP_STATS_EN
  logic [NI-1:0][31:0] pop_cnt, stall_cnt;
`endif

  logic [31:0] fm [NI][1024];
  int          wp [NI] = '{default: 0};
  int          rp [NI] = '{default: 0};
  logic [31:0] dp [NI][3];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sfifo_pop_stream #(.FIFO_D(12), .FIFO_W(32), .FIFO_DLY(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en[g]),
      .flush_req (flush_req[g]),
      .fifo_re   (fifo_re[g]),
      .fifo_fsh  (fifo_fsh[g]),
      .fifo_rd   (fifo_rd[g]),
      .fifo_empt (fifo_empt[g]),
      .fifo_udf  (fifo_udf[g]),
      .fifo_len  (fifo_len[g]),
      .m_vld     (m_vld[g]),
      .m_rdy     (m_rdy[g]),
      .m_dat     (m_dat[g]),
      .busy      (busy[g]),
      .udf_err   (udf_err[g])
`ifdef SFIFO_POP_STATS_EN
      ,
      .pop_cnt   (pop_cnt[g]),
      .stall_cnt (stall_cnt[g])
`endif
    );
    assign fifo_empt[g] = (wp[g] == rp[g]);
    assign fifo_len[g]  = 5'(wp[g] - rp[g]);
    if (g == 0) begin : g_d0
      assign fifo_rd[g] = fm[g][rp[g] & 1023];
    end else begin : g_dn
      assign fifo_rd[g] = dp[g][g-1];
    end
  end

  // FIFO model: read data comes out of a g-stage delay line; rst and flush empty it.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst || fifo_fsh[g]) rp[g] <= wp[g];
      else if (fifo_re[g])    rp[g] <= rp[g] + 1;
      dp[g][0] <= fm[g][rp[g] & 1023];
      dp[g][1] <= dp[g][0];
      dp[g][2] <= dp[g][1];
    end
  end

  task automatic push(input int g, input logic [31:0] v);
    fm[g][wp[g] & 1023] = v;
    wp[g] = wp[g] + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = '0; flush_req = '0; m_rdy = '0; fifo_udf = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int g = 0; g < NI; g++) begin
      total++;
      if ({fifo_re[g], fifo_fsh[g], m_vld[g], busy[g], udf_err[g]} !== 5'b0) begin
        bad++;
        $display("FAIL reset_flags[%0d] got re/fsh/vld/busy/udf=%b want 00000", g,
                 {fifo_re[g], fifo_fsh[g], m_vld[g], busy[g], udf_err[g]});
      end
      total++;
      if (m_dat[g] !== 32'h0) begin
        bad++; $display("FAIL reset_mdat[%0d] got=%h want=0", g, m_dat[g]);
      end
`ifdef SFIFO_POP_STATS_EN
      total++;
      if (pop_cnt[g] !== 32'h0 || stall_cnt[g] !== 32'h0) begin
        bad++; $display("FAIL reset_stats[%0d] got pop=%0d stall=%0d want 0 0", g, pop_cnt[g], stall_cnt[g]);
      end
`endif
    end
  endtask

  task automatic test_stream_dly0();
    do_reset();
    for (int i = 0; i < 8; i++) push(0, 32'(i + 1));
    m_rdy[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) en[0] = 1'b1;
      #1;
      total++;
      if (fifo_re[0] !== (c < 8)) begin
        bad++; $display("FAIL stream0_re c=%0d got=%b want=%b", c, fifo_re[0], (c < 8));
      end
      total++;
      if (m_vld[0] !== (c >= 1 && c <= 8)) begin
        bad++; $display("FAIL stream0_vld c=%0d got=%b want=%b", c, m_vld[0], (c >= 1 && c <= 8));
      end
      if (c >= 1 && c <= 8) begin
        total++;
        if (m_dat[0] !== 32'(c)) begin
          bad++; $display("FAIL stream0_dat c=%0d got=%h want=%h", c, m_dat[0], 32'(c));
        end
      end
      total++;
      if (busy[0] !== (c >= 1 && c <= 8)) begin
        bad++; $display("FAIL stream0_busy c=%0d got=%b want=%b", c, busy[0], (c >= 1 && c <= 8));
      end
    end
    en[0] = 1'b0; m_rdy[0] = 1'b0;
  endtask

  task automatic test_stall_dly2();
    do_reset();
    for (int i = 0; i < 10; i++) push(2, 32'h100 + 32'(i));
    en[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if (fifo_re[2] !== (c < 4)) begin
        bad++; $display("FAIL stall2_re c=%0d got=%b want=%b", c, fifo_re[2], (c < 4));
      end
      total++;
      if (m_vld[2] !== (c >= 3)) begin
        bad++; $display("FAIL stall2_vld c=%0d got=%b want=%b", c, m_vld[2], (c >= 3));
      end
      if (c >= 3) begin
        total++;
        if (m_dat[2] !== 32'h100) begin
          bad++; $display("FAIL stall2_hold c=%0d got=%h want=100", c, m_dat[2]);
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m_rdy[2] = 1'b1;
      #1;
      total++;
      if (m_vld[2] !== 1'b1 || m_dat[2] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL stall2_stream k=%0d got vld=%b dat=%h want 1 %h", k, m_vld[2], m_dat[2], 32'h100 + 32'(k));
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (m_vld[2] !== 1'b0) begin
      bad++; $display("FAIL stall2_end got vld=%b want 0", m_vld[2]);
    end
    en[2] = 1'b0; m_rdy[2] = 1'b0;
  endtask

  task automatic test_flush_dly2();
    do_reset();
    for (int i = 0; i < 10; i++) push(2, 32'h200 + 32'(i));
    en[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) begin flush_req[2] = 1'b1; m_rdy[2] = 1'b1; end
      if (c == 4) begin flush_req[2] = 1'b0; m_rdy[2] = 1'b0; end
      if (c == 5) push(2, 32'h2AA);
      if (c == 10) m_rdy[2] = 1'b1;
      #1;
      if (c == 3) begin
        total++;
        if (fifo_re[2] !== 1'b0) begin
          bad++; $display("FAIL flush_re_suppress got=%b want 0", fifo_re[2]);
        end
        total++;
        if (m_vld[2] !== 1'b1 || m_dat[2] !== 32'h200 || busy[2] !== 1'b1) begin
          bad++; $display("FAIL flush_req_hs got vld=%b dat=%h busy=%b want 1 200 1", m_vld[2], m_dat[2], busy[2]);
        end
      end
      if (c >= 4) begin
        total++;
        if (fifo_fsh[2] !== (c == 4)) begin
          bad++; $display("FAIL flush_fsh c=%0d got=%b want=%b", c, fifo_fsh[2], (c == 4));
        end
      end
      if (c >= 4 && c <= 7) begin
        total++;
        if (fifo_re[2] !== (c == 7)) begin
          bad++; $display("FAIL flush_drain_re c=%0d got=%b want=%b", c, fifo_re[2], (c == 7));
        end
      end
      if (c >= 5 && c <= 9) begin
        total++;
        if (m_vld[2] !== 1'b0) begin
          bad++; $display("FAIL flush_vld c=%0d got=%b dat=%h want vld 0", c, m_vld[2], m_dat[2]);
        end
      end
      if (c == 5) begin
        total++;
        if (busy[2] !== 1'b0) begin
          bad++; $display("FAIL flush_busy got=%b want 0", busy[2]);
        end
      end
      if (c == 10) begin
        total++;
        if (m_vld[2] !== 1'b1 || m_dat[2] !== 32'h2AA) begin
          bad++; $display("FAIL flush_next_word got vld=%b dat=%h want 1 2aa", m_vld[2], m_dat[2]);
        end
      end
      if (c == 11) begin
        total++;
        if (m_vld[2] !== 1'b0) begin
          bad++; $display("FAIL flush_tail got vld=%b want 0", m_vld[2]);
        end
      end
    end
    en[2] = 1'b0; m_rdy[2] = 1'b0;
  endtask

  task automatic test_random_dly1();
    logic [31:0] exq[$];
    logic [31:0] prev_dat;
    logic        prev_stall;
    int          nxt;
    prev_stall = 1'b0; prev_dat = '0; nxt = 0;
    do_reset();
    en[1] = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge clk);
      if ($urandom_range(0, 99) < 55) begin
        push(1, 32'h1000 + 32'(nxt));
        exq.push_back(32'h1000 + 32'(nxt));
        nxt++;
      end
      m_rdy[1] = ($urandom_range(0, 99) < 60);
      #1;
      if (prev_stall) begin
        total++;
        if (m_vld[1] !== 1'b1 || m_dat[1] !== prev_dat) begin
          bad++; $display("FAIL rand_hold c=%0d got vld=%b dat=%h want 1 %h", c, m_vld[1], m_dat[1], prev_dat);
        end
      end
      if (m_vld[1] && m_rdy[1]) begin
        total++;
        if (exq.size() == 0 || m_dat[1] !== exq[0]) begin
          bad++; $display("FAIL rand_order c=%0d got=%h want=%h", c, m_dat[1], (exq.size() != 0) ? exq[0] : 32'hx);
        end
        if (exq.size() != 0) void'(exq.pop_front());
      end
      prev_stall = m_vld[1] && !m_rdy[1];
      prev_dat   = m_dat[1];
    end
    for (int c = 0; c < 1500 && exq.size() != 0; c++) begin
      @(negedge clk);
      m_rdy[1] = 1'b1;
      #1;
      if (m_vld[1]) begin
        total++;
        if (m_dat[1] !== exq[0]) begin
          bad++; $display("FAIL rand_drain got=%h want=%h", m_dat[1], exq[0]);
        end
        void'(exq.pop_front());
      end
    end
    total++;
    if (exq.size() != 0) begin
      bad++; $display("FAIL rand_drain_timeout got left=%0d want 0", exq.size());
    end
    en[1] = 1'b0; m_rdy[1] = 1'b0;
  endtask

  task automatic test_udf_rst();
    do_reset();
    for (int i = 0; i < 3; i++) push(1, 32'h300 + 32'(i));
    en[1] = 1'b1;
    fifo_udf[1] = 1'b1;
    @(negedge clk);
    fifo_udf[1] = 1'b0;
    #1;
    total++;
    if (udf_err[1] !== 1'b1) begin
      bad++; $display("FAIL udf_set got=%b want 1", udf_err[1]);
    end
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (udf_err[1] !== 1'b1 || m_vld[1] !== 1'b1 || busy[1] !== 1'b1 || m_dat[1] !== 32'h300) begin
      bad++; $display("FAIL udf_hold got udf=%b vld=%b busy=%b dat=%h want 1 1 1 300",
                      udf_err[1], m_vld[1], busy[1], m_dat[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (m_vld[1] !== 1'b0 || busy[1] !== 1'b0 || udf_err[1] !== 1'b0 || fifo_fsh[1] !== 1'b0) begin
      bad++; $display("FAIL rst_midop got vld=%b busy=%b udf=%b fsh=%b want 0 0 0 0",
                      m_vld[1], busy[1], udf_err[1], fifo_fsh[1]);
    end
    en[1] = 1'b0;
  endtask

`ifdef SFIFO_POP_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 32'h400 + 32'(i));
    en[0] = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 8)  m_rdy[0] = 1'b1;
      if (c == 13) flush_req[0] = 1'b1;
      if (c == 14) flush_req[0] = 1'b0;
      #1;
      if (c == 13 || c == 16) begin
        total++;
        if (pop_cnt[0] !== 32'd5 || stall_cnt[0] !== 32'd7) begin
          bad++; $display("FAIL stats c=%0d got pop=%0d stall=%0d want 5 7", c, pop_cnt[0], stall_cnt[0]);
        end
      end
    end
    en[0] = 1'b0; m_rdy[0] = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream_dly0();
    test_stall_dly2();
    test_flush_dly2();
    test_random_dly1();
    test_udf_rst();
`ifdef SFIFO_POP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
